// File: rtl/grid_write_arbiter.sv
// Grid-RAM write-port arbiter: round-robin between two paint requesters,
// plus a full-grid clear sweep followed by a one-cycle drain bubble.
module grid_write_arbiter #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned GRID_CELLS  = 4096,
  parameter int unsigned CLEAR_COLOR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] wrdata
);

  // One extra bit lets GRID_CELLS == 2**ADDR_W finish without wrapping.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CELL = CNT_W'(GRID_CELLS - 1);
  localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_COLOR);
  localparam bit SINGLE_CELL = (GRID_CELLS == 1);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              last_grant;
  logic              last_grant_next;
  logic              wren_next;
  logic [ADDR_W-1:0] wraddress_next;
  logic [DATA_W-1:0] wrdata_next;
  logic              ack0_next;
  logic              ack1_next;
  logic              clear_busy_next;

  logic eff0;
  logic eff1;
  logic grant0;
  logic grant1;

  // A requester acked last cycle is masked once so a held level is not granted twice.
  assign eff0   = req0 & ~ack0;
  assign eff1   = req1 & ~ack1;
  assign grant0 = eff0 & (~eff1 | last_grant);
  assign grant1 = eff1 & (~eff0 | ~last_grant);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_ARB;
      cnt        <= '0;
      last_grant <= 1'b1;
      wren       <= 1'b0;
      wraddress  <= '0;
      wrdata     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      last_grant <= last_grant_next;
      wren       <= wren_next;
      wraddress  <= wraddress_next;
      wrdata     <= wrdata_next;
      ack0       <= ack0_next;
      ack1       <= ack1_next;
      clear_busy <= clear_busy_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    wren_next       = 1'b0;
    wraddress_next  = wraddress;
    wrdata_next     = wrdata;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    clear_busy_next = 1'b0;

    case (state)
      ST_ARB: begin
        if (clear_req) begin
          state_next      = SINGLE_CELL ? ST_DRAIN : ST_CLEAR;
          cnt_next        = CNT_W'(1);
          wren_next       = 1'b1;
          wraddress_next  = '0;
          wrdata_next     = CLR_DATA;
          clear_busy_next = 1'b1;
        end else if (grant0) begin
          wren_next       = 1'b1;
          wraddress_next  = addr0;
          wrdata_next     = data0;
          ack0_next       = 1'b1;
          last_grant_next = 1'b0;
        end else if (grant1) begin
          wren_next       = 1'b1;
          wraddress_next  = addr1;
          wrdata_next     = data1;
          ack1_next       = 1'b1;
          last_grant_next = 1'b1;
        end
      end

      ST_CLEAR: begin
        wren_next       = 1'b1;
        wraddress_next  = cnt[ADDR_W-1:0];
        wrdata_next     = CLR_DATA;
        clear_busy_next = 1'b1;
        cnt_next        = cnt + CNT_W'(1);
        if (cnt == LAST_CELL) begin
          state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        cnt_next   = '0;
        state_next = ST_ARB;
      end

      default: begin
        cnt_next   = '0;
        state_next = ST_ARB;
      end
    endcase
  end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Directed bench for grid_write_arbiter: a behavioural reference model is
// compared every cycle, and hand-computed literals pin key cycles.
module tb_grid_write_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned GRID   = 16;
  localparam int unsigned CLR    = 9;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              clear_req = 1'b0;
  logic              clear_busy;
  logic              req0 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [DATA_W-1:0] data0 = '0;
  logic              ack0;
  logic              req1 = 1'b0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [DATA_W-1:0] data1 = '0;
  logic              ack1;
  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic [DATA_W-1:0] wrdata;

  int n_tests = 0;
  int n_fail  = 0;

  grid_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRID_CELLS(GRID), .CLEAR_COLOR(CLR)
  ) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .wren(wren), .wraddress(wraddress), .wrdata(wrdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: sweep progress as "cells left to write", arbitration by rule.
  int          m_left  = 0;
  bit          m_drain = 0;
  int          m_last  = 1;
  bit          m_wren = 0, m_ack0 = 0, m_ack1 = 0, m_busy = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left = 0; m_drain = 0; m_last = 1;
      m_wren = 0; m_ack0 = 0; m_ack1 = 0; m_busy = 0;
      m_addr = '0; m_data = '0;
    end else begin
      bit e0, e1;
      e0 = req0 && !m_ack0;
      e1 = req1 && !m_ack1;
      m_wren = 0; m_ack0 = 0; m_ack1 = 0; m_busy = 0;
      if (m_left > 0) begin
        m_wren = 1; m_busy = 1;
        m_addr = ADDR_W'(GRID - m_left);
        m_data = DATA_W'(CLR);
        m_left--;
        if (m_left == 0) m_drain = 1;
      end else if (m_drain) begin
        m_drain = 0;
      end else if (clear_req) begin
        m_wren = 1; m_busy = 1;
        m_addr = '0;
        m_data = DATA_W'(CLR);
        m_left = GRID - 1;
        if (m_left == 0) m_drain = 1;
      end else if (e0 && (!e1 || m_last == 1)) begin
        m_wren = 1; m_ack0 = 1; m_addr = addr0; m_data = data0; m_last = 0;
      end else if (e1) begin
        m_wren = 1; m_ack1 = 1; m_addr = addr1; m_data = data1; m_last = 1;
      end
    end
  end

  always @(negedge clock) begin
    check("model_wren", 32'(wren), 32'(m_wren));
    check("model_ack0", 32'(ack0), 32'(m_ack0));
    check("model_ack1", 32'(ack1), 32'(m_ack1));
    check("model_busy", 32'(clear_busy), 32'(m_busy));
    check("model_addr", 32'(wraddress), 32'(m_addr));
    check("model_data", 32'(wrdata), 32'(m_data));
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check_idle(input string name);
    check({name, "_wren"}, 32'(wren), 32'd0);
    check({name, "_busy"}, 32'(clear_busy), 32'd0);
    check({name, "_ack0"}, 32'(ack0), 32'd0);
    check({name, "_ack1"}, 32'(ack1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset with pending requests, before any clock edge.
    req0 = 1'b1; addr0 = 12'h0AA; data0 = 4'h1; clear_req = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_idle("rst_async");
    check("rst_async_addr", 32'(wraddress), 32'd0);
    check("rst_async_data", 32'(wrdata), 32'd0);
    cyc(); cyc();
    check_idle("rst_hold");
    reset = 1'b0; clear_req = 1'b0; req0 = 1'b0;
    cyc();

    // Single requester: one write every two cycles.
    req0 = 1'b1; addr0 = 12'h123; data0 = 4'h5;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("single_wren", 32'(wren), 32'(k % 2));
      check("single_ack0", 32'(ack0), 32'(k % 2));
      if (k % 2 == 1) begin
        check("single_addr", 32'(wraddress), 32'h123);
        check("single_data", 32'(wrdata), 32'h5);
      end
    end
    req0 = 1'b0;
    cyc();

    // Contention after reset: requester 0 wins the first tie, then alternate.
    reset = 1'b1; cyc(); reset = 1'b0;
    req0 = 1'b1; addr0 = 12'h010; data0 = 4'h3;
    req1 = 1'b1; addr1 = 12'h020; data1 = 4'h7;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("cont_wren", 32'(wren), 32'd1);
      check("cont_ack0", 32'(ack0), 32'(k % 2));
      check("cont_ack1", 32'(ack1), 32'((k + 1) % 2));
      check("cont_addr", 32'(wraddress), (k % 2 == 1) ? 32'h010 : 32'h020);
      check("cont_data", 32'(wrdata), (k % 2 == 1) ? 32'h3 : 32'h7);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    // Clear sweep with requester 1 waiting.
    req1 = 1'b1; addr1 = 12'h2AB; data1 = 4'hC; clear_req = 1'b1;
    for (int k = 0; k < int'(GRID); k++) begin
      cyc();
      clear_req = 1'b0;
      check("clr_wren", 32'(wren), 32'd1);
      check("clr_busy", 32'(clear_busy), 32'd1);
      check("clr_addr", 32'(wraddress), 32'(k));
      check("clr_data", 32'(wrdata), 32'(CLR));
      check("clr_ack1", 32'(ack1), 32'd0);
    end
    cyc();
    check_idle("clr_drain");
    cyc();
    check("clr_after_ack1", 32'(ack1), 32'd1);
    check("clr_after_addr", 32'(wraddress), 32'h2AB);
    check("clr_after_data", 32'(wrdata), 32'hC);
    req1 = 1'b0;
    cyc();

    // Clear and request on the same edge: clear wins, ack after the bubble.
    clear_req = 1'b1; req0 = 1'b1; addr0 = 12'h3C4; data0 = 4'h6;
    cyc();
    clear_req = 1'b0;
    check("sim_first_addr", 32'(wraddress), 32'd0);
    check("sim_first_data", 32'(wrdata), 32'(CLR));
    check("sim_first_ack0", 32'(ack0), 32'd0);
    for (int k = 1; k <= int'(GRID); k++) begin
      cyc();
      check("sim_wait_ack0", 32'(ack0), 32'd0);
    end
    cyc();
    check("sim_ack0", 32'(ack0), 32'd1);
    check("sim_addr", 32'(wraddress), 32'h3C4);
    req0 = 1'b0;
    cyc();

    // Reset in the middle of a clear abandons the sweep.
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    check("mid_addr7", 32'(wraddress), 32'd7);
    check("mid_busy7", 32'(clear_busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_idle("mid_async");
    check("mid_async_addr", 32'(wraddress), 32'd0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_idle("mid_idle");
    end
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    check("restart_addr0", 32'(wraddress), 32'd0);
    check("restart_wren", 32'(wren), 32'd1);
    cyc();
    check("restart_addr1", 32'(wraddress), 32'd1);
    for (int k = 0; k < int'(GRID); k++) cyc();
    check_idle("end_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
